// File: rtl/motor_drive_ramp.sv
// rtl/motor_drive_ramp.sv - duty ramp FSM with per-wheel PWM and H-bridge direction outputs
module motor_drive_ramp #(
  parameter int PWM_BITS  = 8,
  parameter int RAMP_DIV  = 1000,
  parameter int DUTY_STEP = 4,
  parameter int DUTY_MAX  = 200,
  parameter int TURN_DUTY = 128
) (
  input  logic                clkin,
  input  logic                reset_n,
  input  logic [6:0]          direction,
  input  logic                start_acc,
  input  logic                start_dec,
  output logic                accelerated,
  output logic                decelerated,
  output logic                pwm_left,
  output logic                pwm_right,
  output logic                dir_left,
  output logic                dir_right,
  output logic [PWM_BITS-1:0] duty
);

  localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(RAMP_DIV - 1);
  localparam logic [PWM_BITS-1:0] DMAX     = PWM_BITS'(DUTY_MAX);
  localparam logic [PWM_BITS-1:0] DSTEP    = PWM_BITS'(DUTY_STEP);
  localparam logic [PWM_BITS-1:0] TDUTY    = PWM_BITS'(TURN_DUTY);

  localparam logic [6:0] DIR_FORWARD  = 7'b0000001;
  localparam logic [6:0] DIR_BACKWARD = 7'b0000100;
  localparam logic [6:0] DIR_LEFT     = 7'b0001000;
  localparam logic [6:0] DIR_RIGHT    = 7'b0010000;
  localparam logic [6:0] DIR_ACC      = 7'b0100000;
  localparam logic [6:0] DIR_DEC      = 7'b1000000;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_t;

  ramp_state_t         state;
  logic [PRE_W-1:0]    presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                done_up;
  logic                done_dn;

  logic [31:0]         up_sum;
  logic [PWM_BITS-1:0] duty_up;
  logic [PWM_BITS-1:0] duty_dn;
  logic                step_now;
  logic                at_max;
  logic                at_zero;
  logic                acc_fire;
  logic                dec_fire;
  logic [PWM_BITS-1:0] eff;
  logic                dir_l_next;
  logic                dir_r_next;

  // Saturating step arithmetic done 32 bits wide so neither direction can wrap.
  always_comb begin
    up_sum   = 32'(duty) + 32'(DUTY_STEP);
    duty_up  = (up_sum >= 32'(DUTY_MAX)) ? DMAX : up_sum[PWM_BITS-1:0];
    duty_dn  = (32'(duty) <= 32'(DUTY_STEP)) ? '0 : duty - DSTEP;
    step_now = (presc == PRE_LAST);
    at_max   = (duty == DMAX);
    at_zero  = (duty == '0);
  end

  // Completion pulses: either one cycle after the final step, or immediately
  // when a request arrives in HOLD that is already satisfied. Dec has priority.
  always_comb begin
    dec_fire = done_dn | ((state == HOLD) & start_dec & at_zero);
    acc_fire = ~dec_fire &
               (done_up | ((state == HOLD) & ~start_dec & start_acc & at_max));
  end

  always_comb begin
    eff        = '0;
    dir_l_next = 1'b1;
    dir_r_next = 1'b1;
    case (direction)
      DIR_FORWARD, DIR_ACC, DIR_DEC: eff = duty;
      DIR_BACKWARD: begin
        eff        = duty;
        dir_l_next = 1'b0;
        dir_r_next = 1'b0;
      end
      DIR_LEFT: begin
        eff        = TDUTY;
        dir_l_next = 1'b0;
      end
      DIR_RIGHT: begin
        eff        = TDUTY;
        dir_r_next = 1'b0;
      end
      default: eff = '0;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      state       <= HOLD;
      duty        <= '0;
      presc       <= '0;
      pwm_cnt     <= '0;
      done_up     <= 1'b0;
      done_dn     <= 1'b0;
      accelerated <= 1'b0;
      decelerated <= 1'b0;
      pwm_left    <= 1'b0;
      pwm_right   <= 1'b0;
      dir_left    <= 1'b1;
      dir_right   <= 1'b1;
    end else begin
      pwm_cnt     <= pwm_cnt + 1'b1;
      pwm_left    <= (pwm_cnt < eff);
      pwm_right   <= (pwm_cnt < eff);
      dir_left    <= dir_l_next;
      dir_right   <= dir_r_next;
      accelerated <= acc_fire;
      decelerated <= dec_fire;
      done_up     <= 1'b0;
      done_dn     <= 1'b0;

      case (state)
        HOLD: begin
          if (start_dec) begin
            if (!at_zero) begin
              state <= RAMP_DOWN;
              presc <= '0;
            end
          end else if (start_acc && !at_max) begin
            state <= RAMP_UP;
            presc <= '0;
          end
        end

        RAMP_UP: begin
          if (start_dec) begin
            state <= RAMP_DOWN;
            presc <= '0;
          end else if (step_now) begin
            presc <= '0;
            duty  <= duty_up;
            if (duty_up == DMAX) begin
              state   <= HOLD;
              done_up <= 1'b1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end

        RAMP_DOWN: begin
          if (start_acc && !start_dec) begin
            state <= RAMP_UP;
            presc <= '0;
          end else if (step_now) begin
            presc <= '0;
            duty  <= duty_dn;
            if (duty_dn == '0) begin
              state   <= HOLD;
              done_dn <= 1'b1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end

        default: begin
          state <= HOLD;
          presc <= '0;
        end
      endcase
    end
  end

endmodule
